d_cache_nway: RTL and testbench
===============================

// Module: d_cache_nway
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache for the pipelined MIPS core.
//  Generalises the dual-port 2-way d_cache into configurable ways/sets/line size with byte-enable writes and dirty tracking.
//  Uses a single valid/ready request port and a line-wide handshake to the backing memory model.
//  Sits between MEM stage and data memory; stall pipeline while req_ready=0 or response pending.
// PARAMETERS
//  ADDR_W   32  byte address width
//  WAYS     2   associativity, power of 2, 1..8
//  SETS     64  number of sets, power of 2
//  WORDS    16  32-bit words per line, power of 2; LINE_W = 32*WORDS
//  derived: OFF_W=log2(WORDS), SET_W=log2(SETS), TAG_W=ADDR_W-SET_W-OFF_W-2
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       asynchronous, active-low reset
//  req_valid  in   1       CPU request valid
//  req_ready  out  1       cache can accept request (high only in IDLE)
//  req_we     in   1       1=store, 0=load
//  req_be     in   4       byte enables for store (ignored for load)
//  req_addr   in   ADDR_W  byte address; bits[1:0] ignored
//  req_wdata  in   32      store data
//  rsp_valid  out  1       one-cycle pulse: request complete
//  rsp_rdata  out  32      word at req_addr (post-merge value for stores)
//  mem_req    out  1       memory transaction pending
//  mem_we     out  1       1=line writeback, 0=line refill
//  mem_addr   out  ADDR_W  line-aligned address (low OFF_W+2 bits zero)
//  mem_wdata  out  LINE_W  victim line for writeback; word0 in [31:0]
//  mem_rdata  in   LINE_W  refill line, sampled when mem_ready=1
//  mem_ready  in   1       one-cycle completion pulse from memory
// BEHAVIOUR
//  Reset (rst=0, async): all valid/dirty bits=0, per-set round-robin pointers=0, state=IDLE;
//   req_ready=1, rsp_valid=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Tag/data arrays not cleared.
//  Reset mid-transaction aborts it; mem_req drops asynchronously, in-flight request is lost.
//  States: IDLE, LOOKUP, WB, REFILL, RESP.
//  IDLE: req_ready=1; on req_valid&&req_ready latch we/be/addr/wdata -> LOOKUP.
//  LOOKUP: compare tag against all valid ways of set (at most one way matches).
//   hit load -> RESP with rsp_rdata=word[addr[OFF_W+1:2]].
//   hit store -> merge bytes where req_be[i]=1, set dirty, rsp_rdata=merged word -> RESP.
//   miss: victim = lowest-index invalid way, else rr[set]; dirty victim -> WB; else -> REFILL.
//  WB: mem_req=1, mem_we=1, mem_addr={victim tag,set,0}, mem_wdata=victim line; held stable until mem_ready -> REFILL.
//  REFILL: mem_req=1, mem_we=0, mem_addr={req tag,set,0}; on mem_ready write mem_rdata into victim,
//   tag=req tag, valid=1, dirty=0; if victim came from rr, rr[set]=(rr[set]+1) mod WAYS -> LOOKUP (re-lookup hits).
//  RESP: rsp_valid=1 for exactly this cycle -> IDLE. Next request accepted no earlier than the cycle after RESP.
//  Latency: hit = accept edge + 2 cycles to rsp_valid; clean miss adds REFILL wait + 1; dirty miss adds WB wait too.
//  mem_ready while mem_req=0 is ignored. req_valid outside IDLE is ignored (not queued).
//  WAYS=1 degenerates to direct-mapped; rr pointer unused.
// CONFIGURATION
//  D_CACHE_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_wbs (32 bits each, reset 0, saturate at all-ones);
//   hits += 1 per LOOKUP hit on first lookup only, misses += 1 per LOOKUP miss, wbs += 1 per WB completion.
//  Undefined: ports and counters absent; no other behaviour change.
// TESTING
//  Reset, then load 0x0000_1040 -> REFILL mem_addr=0x0000_1040; return line word0=0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF.
//  Repeat same load -> no mem_req; rsp_valid exactly 2 cycles after accept.
//  Store be=4'b0011 wdata=0x1234_5678 to 0x0000_1040 -> rsp_rdata=0xDEAD_5678, dirty set, no memory traffic.
//  WAYS=2: load 0x0000_2040 then 0x0000_3040 (same set) -> second miss evicts dirty 0x1040 line:
//   WB mem_addr=0x0000_1040, mem_wdata[31:0]=0xDEAD_5678, then REFILL 0x0000_3040.
//  Stretch mem_ready by 20 cycles -> mem_req/mem_addr/mem_wdata stable throughout, req_ready=0.
//  Assert rst=0 during REFILL -> mem_req=0 immediately; reload of 0x0000_1040 misses (valid cleared).

Source files
------------

// File: rtl/d_cache_nway.sv
// N-way set-associative write-back / write-allocate data cache with a line-wide memory handshake.
// Optional hit/miss/writeback counters are built when D_CACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; latches it on req_valid_i
// LOOKUP | tag compare; hit completes, miss picks a victim
// WB     | dirty victim line written back, waiting on mem_ready_i
// REFILL | requested line fetched into the victim way, waiting on mem_ready_i
// RESP   | rsp_valid_o high for this single cycle
module d_cache_nway #(
    parameter int ADDR_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 16,
    localparam int LINE_W = 32 * WORDS,
    localparam int OFF_W  = $clog2(WORDS),
    localparam int SET_W  = $clog2(SETS),
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W - 2,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [3:0]        req_be_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
`ifdef D_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits_o,
    output logic [31:0]       stat_misses_o,
    output logic [31:0]       stat_wbs_o
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;

    state_t              state_q;
    logic                req_we_q;
    logic [3:0]          req_be_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [31:0]         req_wdata_q;
    logic [WAY_W-1:0]    victim_q;
    logic                victim_rr_q;
    logic                first_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]   data_q  [WAYS][SETS];
    logic [SETS-1:0]     valid_q [WAYS];
    logic [SETS-1:0]     dirty_q [WAYS];
    logic [WAY_W-1:0]    rr_q    [SETS];

`ifdef D_CACHE_STATS_EN
    logic [31:0]         hits_q;
    logic [31:0]         misses_q;
    logic [31:0]         wbs_q;
`endif

    logic [SET_W-1:0]    set_idx;
    logic [OFF_W-1:0]    word_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    vict_way;
    logic [LINE_W-1:0]   hit_line;
    logic [31:0]         hit_word;
    logic [31:0]         merged;
    logic [ADDR_W-1:0]   req_line_addr;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr_i[1:0];

    assign set_idx       = req_addr_q[OFF_W+2 +: SET_W];
    assign word_idx      = req_addr_q[2 +: OFF_W];
    assign req_tag       = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_line_addr = {req_tag, set_idx, {(OFF_W+2){1'b0}}};

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][set_idx] && (tag_q[w][set_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][set_idx]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vict_way = inv_found ? inv_way : rr_q[set_idx];
    end

    assign hit_line = data_q[hit_way][set_idx];
    assign hit_word = hit_line[{word_idx, 5'b0} +: 32];

    always_comb begin
        merged = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (req_be_q[b]) merged[b*8 +: 8] = req_wdata_q[b*8 +: 8];
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (state_q == LOOKUP && hit && req_we_q) begin
            data_q[hit_way][set_idx][{word_idx, 5'b0} +: 32] <= merged;
        end
        if (state_q == REFILL && mem_ready_i) begin
            data_q[victim_q][set_idx] <= mem_rdata_i;
            tag_q[victim_q][set_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            first_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
`ifdef D_CACHE_STATS_EN
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_we_q    <= req_we_i;
                        req_be_q    <= req_be_i;
                        req_addr_q  <= req_addr_i;
                        req_wdata_q <= req_wdata_i;
                        first_q     <= 1'b1;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= req_we_q ? merged : hit_word;
                        if (req_we_q) dirty_q[hit_way][set_idx] <= 1'b1;
`ifdef D_CACHE_STATS_EN
                        if (first_q && hits_q != '1) hits_q <= hits_q + 32'd1;
`endif
                        state_q <= RESP;
                    end else begin
                        victim_q    <= vict_way;
                        victim_rr_q <= !inv_found;
                        first_q     <= 1'b0;
                        mem_req_q   <= 1'b1;
`ifdef D_CACHE_STATS_EN
                        if (misses_q != '1) misses_q <= misses_q + 32'd1;
`endif
                        if (valid_q[vict_way][set_idx] && dirty_q[vict_way][set_idx]) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[vict_way][set_idx], set_idx, {(OFF_W+2){1'b0}}};
                            mem_wdata_q <= data_q[vict_way][set_idx];
                            state_q     <= WB;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= req_line_addr;
                            state_q    <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (mem_ready_i) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= req_line_addr;
`ifdef D_CACHE_STATS_EN
                        if (wbs_q != '1) wbs_q <= wbs_q + 32'd1;
`endif
                        state_q    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready_i) begin
                        valid_q[victim_q][set_idx] <= 1'b1;
                        dirty_q[victim_q][set_idx] <= 1'b0;
                        if (victim_rr_q) begin
                            rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                                 : rr_q[set_idx] + 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= LOOKUP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef D_CACHE_STATS_EN
    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
    assign stat_wbs_o    = wbs_q;
`endif

endmodule

// File: tb/tb_d_cache_nway.sv
// Directed bench for d_cache_nway (default parameters: 2 ways, 64 sets, 16-word lines).
module tb_d_cache_nway;

    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [3:0]    req_be;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    d_cache_nway dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] make_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_mem(input string tag, input logic we, input logic [31:0] addr);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(we));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
    endtask

    task automatic mem_reply(input logic [LW-1:0] line);
        mem_rdata = line;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp, output int lat,
                            output logic saw_mem);
        lat     = 1;
        saw_mem = mem_req;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
            if (mem_req) saw_mem = 1'b1;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp));
        step();
        chk({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    logic [LW-1:0] line_a, line_b, line_c, line_d;
    logic [LW-1:0] w0;
    logic [31:0]   a0;
    logic          stable;
    logic          saw;
    int            lat;

    initial begin
        rst_ni    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        line_a = make_line(32'h1000_0000);
        line_a[31:0] = 32'hDEAD_BEEF;
        line_b = make_line(32'hAAAA_0000);
        line_c = make_line(32'hBBBB_0000);
        line_d = make_line(32'h1111_1111);
        line_d[63:32] = 32'hCAFE_F00D;

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata_lo", mem_wdata[63:0], 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Stray memory completion in IDLE must be ignored.
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("stray_ready_mem_req", 64'(mem_req), 64'd0);
        chk("stray_ready_req_ready", 64'(req_ready), 64'd1);

        // Cold miss on 0x1040 (set 1, tag 1) -> refill into way 0.
        send(1'b0, 4'h0, 32'h0000_1040, 32'h0);
        wait_mem("miss1040", 1'b0, 32'h0000_1040);
        chk("miss1040_busy", 64'(req_ready), 64'd0);
        mem_reply(line_a);
        wait_rsp("miss1040", 32'hDEAD_BEEF, lat, saw);

        // Same load hits: response two cycles after accept, no memory traffic.
        send(1'b0, 4'h0, 32'h0000_1040, 32'h0);
        wait_rsp("hit1040", 32'hDEAD_BEEF, lat, saw);
        chk("hit1040_latency", 64'(lat), 64'd2);
        chk("hit1040_no_mem", 64'(saw), 64'd0);

        // Partial store hit merges the low half-word.
        send(1'b1, 4'b0011, 32'h0000_1040, 32'h1234_5678);
        wait_rsp("st1040", 32'hDEAD_5678, lat, saw);
        chk("st1040_latency", 64'(lat), 64'd2);
        chk("st1040_no_mem", 64'(saw), 64'd0);

        // Word 1 of the line is unchanged by the store.
        send(1'b0, 4'h0, 32'h0000_1044, 32'h0);
        wait_rsp("hit1044", 32'h1000_0001, lat, saw);

        // 0x2040 fills the invalid way 1 cleanly.
        send(1'b0, 4'h0, 32'h0000_2040, 32'h0);
        wait_mem("miss2040", 1'b0, 32'h0000_2040);
        mem_reply(line_b);
        wait_rsp("miss2040", 32'hAAAA_0000, lat, saw);

        // 0x3040: set full, rr=0 picks dirty way 0 -> writeback of 0x1040 first.
        send(1'b0, 4'h0, 32'h0000_3040, 32'h0);
        wait_mem("wb1040", 1'b1, 32'h0000_1040);
        chk("wb1040_word0", 64'(mem_wdata[31:0]), 64'h0000_0000_DEAD_5678);
        chk("wb1040_word1", 64'(mem_wdata[63:32]), 64'h0000_0000_1000_0001);
        a0 = mem_addr;
        w0 = mem_wdata;
        stable = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a0 ||
                mem_wdata !== w0 || req_ready !== 1'b0) stable = 1'b0;
        end
        req_valid = 1'b0;
        chk("wb_hold_stable", 64'(stable), 64'd1);
        mem_reply(make_line(32'h5555_0000));
        wait_mem("rf3040", 1'b0, 32'h0000_3040);
        mem_reply(line_c);
        wait_rsp("miss3040", 32'hBBBB_0000, lat, saw);

        send(1'b0, 4'h0, 32'h0000_2040, 32'h0);
        wait_rsp("hit2040", 32'hAAAA_0000, lat, saw);
        chk("hit2040_no_mem", 64'(saw), 64'd0);

        // Reset asserted mid-refill aborts the transaction at once.
        send(1'b0, 4'h0, 32'h0000_1040, 32'h0);
        wait_mem("abort1040", 1'b0, 32'h0000_1040);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Previously resident 0x3040 now misses: valid bits were cleared.
        send(1'b0, 4'h0, 32'h0000_3040, 32'h0);
        wait_mem("post_rst3040", 1'b0, 32'h0000_3040);
        mem_reply(line_c);
        wait_rsp("post_rst3040", 32'hBBBB_0000, lat, saw);

        send(1'b0, 4'h0, 32'h0000_1040, 32'h0);
        wait_mem("post_rst1040", 1'b0, 32'h0000_1040);
        mem_reply(line_d);
        wait_rsp("post_rst1040", 32'h1111_1111, lat, saw);

        send(1'b0, 4'h0, 32'h0000_1044, 32'h0);
        wait_rsp("post_rst1044", 32'hCAFE_F00D, lat, saw);
        chk("post_rst1044_no_mem", 64'(saw), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
